// File: rtl/mulpop_pkg.sv
// Shared types and constants for the multiply/popcount job scheduler.
package mulpop_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int ST_OVF = 0;
    localparam int ST_TMO = 1;

    localparam int DEF_OPW = 24;
    localparam int DEF_RW  = 32;
    localparam int POPW    = 6;

    localparam logic REQ_BUS  = 1'b0;
    localparam logic REQ_GPIO = 1'b1;

endpackage

// File: rtl/mulpop_rr_arb2.sv
// Two-way round-robin grant; rr_ptr only breaks ties when both requesters are valid.
module mulpop_rr_arb2
    import mulpop_pkg::*;
(
    input  logic [1:0] req_valid,
    input  logic       rr_ptr,
    output logic       grant_valid,
    output logic       grant_id
);

    always_comb begin
        grant_valid = |req_valid;
        case (req_valid)
            2'b11:   grant_id = rr_ptr;
            2'b10:   grant_id = REQ_GPIO;
            default: grant_id = REQ_BUS;
        endcase
    end

endmodule

// File: rtl/mulpop_job_sched.sv
// Shares one multiply/popcount engine between the bus (0) and GPIO (1) requesters,
// with a WAIT timeout and per-owner response return.
//
//   state | meaning
//   IDLE  | no job; grant a requester and latch its operands
//   ISSUE | pulse eng_start (registered, visible next cycle), clear timeout counter
//   WAIT  | wait for eng_done or timeout expiry
//   RESP  | hold response for the owner until it takes it
module mulpop_job_sched
    import mulpop_pkg::*;
#(
    parameter int OPW     = DEF_OPW,
    parameter int RW      = DEF_RW,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [OPW-1:0]   req0_a1,
    input  logic [OPW-1:0]   req0_a2,
    input  logic [OPW-1:0]   req1_a1,
    input  logic [OPW-1:0]   req1_a2,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [RW-1:0]    rsp_w,
    output logic [POPW-1:0]  rsp_l,
    output logic [1:0]       rsp_status,
    output logic             eng_start,
    output logic [OPW-1:0]   eng_a1,
    output logic [OPW-1:0]   eng_a2,
    input  logic             eng_done,
    input  logic [RW-1:0]    eng_w,
    input  logic [POPW-1:0]  eng_l,
    input  logic             eng_ovf,
    output logic             busy,
    output logic [15:0]      op_count
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_ISSUE = ISSUE;
    localparam logic [1:0] S_WAIT  = WAIT;
    localparam logic [1:0] S_RESP  = RESP;

    logic [1:0]    state;
    logic          rr_ptr;
    logic          owner;
    logic [TW-1:0] tmo_cnt;
    logic [15:0]   op_count_q;
    logic          grant_valid;
    logic          grant_id;
    logic [1:0]    owner_mask;
    logic [1:0]    tmo_status;

    mulpop_rr_arb2 u_arb (
        .req_valid   (req_valid),
        .rr_ptr      (rr_ptr),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign owner_mask = owner ? 2'b10 : 2'b01;
    assign busy       = (state != S_IDLE);
    assign op_count   = op_count_q;

    always_comb begin
        tmo_status         = 2'b00;
        tmo_status[ST_TMO] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state      <= S_IDLE;
            rr_ptr     <= REQ_BUS;
            owner      <= REQ_BUS;
            tmo_cnt    <= '0;
            op_count_q <= '0;
            req_ready  <= '0;
            rsp_valid  <= '0;
            rsp_w      <= '0;
            rsp_l      <= '0;
            rsp_status <= '0;
            eng_start  <= 1'b0;
            eng_a1     <= '0;
            eng_a2     <= '0;
        end else begin
            req_ready <= '0;
            eng_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_valid) begin
                        req_ready <= grant_id ? 2'b10 : 2'b01;
                        owner     <= grant_id;
                        eng_a1    <= grant_id ? req1_a1 : req0_a1;
                        eng_a2    <= grant_id ? req1_a2 : req0_a2;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    eng_start <= 1'b1;
                    tmo_cnt   <= '0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    // eng_done has priority over a coincident expiry
                    if (eng_done) begin
                        rsp_w              <= eng_w;
                        rsp_l              <= eng_l;
                        rsp_status         <= 2'b00;
                        rsp_status[ST_OVF] <= eng_ovf;
                        rsp_valid          <= owner_mask;
                        state              <= S_RESP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        rsp_w      <= '0;
                        rsp_l      <= '0;
                        rsp_status <= tmo_status;
                        rsp_valid  <= owner_mask;
                        state      <= S_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid  <= '0;
                        rr_ptr     <= ~owner;
                        op_count_q <= op_count_q + 16'd1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mulpop_job_sched.sv
// Self-checking bench: job-level reference model compared every cycle, directed boundary cases, random traffic.
`timescale 1ns/1ps
module tb_mulpop_job_sched;
    localparam int OPW = 24;
    localparam int RW = 32;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    logic [1:0] req_valid = 2'b00;
    logic [1:0] req_ready;
    logic [OPW-1:0] req0_a1 = '0, req0_a2 = '0, req1_a1 = '0, req1_a2 = '0;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready = 2'b00;
    logic [RW-1:0] rsp_w;
    logic [5:0] rsp_l;
    logic [1:0] rsp_status;
    logic eng_start;
    logic [OPW-1:0] eng_a1, eng_a2;
    logic eng_done = 1'b0;
    logic [RW-1:0] eng_w = '0;
    logic [5:0] eng_l = '0;
    logic eng_ovf = 1'b0;
    logic busy;
    logic [15:0] op_count;

    mulpop_job_sched #(.OPW(OPW), .RW(RW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .n_reset(n_reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a1(req0_a1), .req0_a2(req0_a2), .req1_a1(req1_a1), .req1_a2(req1_a2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_w(rsp_w), .rsp_l(rsp_l), .rsp_status(rsp_status),
        .eng_start(eng_start), .eng_a1(eng_a1), .eng_a2(eng_a2),
        .eng_done(eng_done), .eng_w(eng_w), .eng_l(eng_l), .eng_ovf(eng_ovf),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    function automatic void chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model (job-level view) ----------------
    bit m_active, m_pend, m_owner, m_rr;
    int m_age, m_waited;
    logic [OPW-1:0] m_a1, m_a2;
    logic [RW-1:0] m_w;
    logic [5:0] m_l;
    logic [1:0] m_st;
    logic [15:0] m_count;

    task automatic model_step();
        if (!n_reset) begin
            m_active = 0; m_pend = 0; m_owner = 0; m_rr = 0; m_age = 0; m_waited = 0;
            m_a1 = '0; m_a2 = '0; m_w = '0; m_l = '0; m_st = '0; m_count = '0;
        end else if (!m_active) begin
            if (req_valid != 2'b00) begin
                m_owner  = (req_valid == 2'b11) ? m_rr : req_valid[1];
                m_a1     = m_owner ? req1_a1 : req0_a1;
                m_a2     = m_owner ? req1_a2 : req0_a2;
                m_active = 1; m_age = 1; m_waited = 0;
            end
        end else if (m_age == 1) begin
            m_age = 2;
        end else if (!m_pend) begin
            m_age++;
            m_waited++;
            if (eng_done) begin
                m_pend = 1; m_w = eng_w; m_l = eng_l; m_st = {1'b0, eng_ovf};
            end else if (m_waited == TIMEOUT) begin
                m_pend = 1; m_w = '0; m_l = '0; m_st = 2'b10;
            end
        end else if (rsp_ready[m_owner]) begin
            m_pend = 0; m_active = 0; m_age = 0;
            m_rr = !m_owner;
            m_count = m_count + 16'd1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            logic [1:0] oh;
            oh = m_owner ? 2'b10 : 2'b01;
            chk("req_ready", req_ready, (m_active && m_age == 1) ? oh : 2'b00);
            chk("eng_start", eng_start, (m_active && m_age == 2) ? 1'b1 : 1'b0);
            chk("busy", busy, m_active);
            chk("eng_a1", eng_a1, m_a1);
            chk("eng_a2", eng_a2, m_a2);
            chk("rsp_valid", rsp_valid, m_pend ? oh : 2'b00);
            chk("rsp_w", rsp_w, m_w);
            chk("rsp_l", rsp_l, m_l);
            chk("rsp_status", rsp_status, m_st);
            chk("op_count", op_count, m_count);
        end
    end

    // ---------------- engine emulation ----------------
    int eng_delay = 3;
    bit eng_rand = 0;
    bit eng_force = 0;
    logic [RW-1:0] f_w = '0;
    logic [5:0] f_l = '0;
    logic f_ovf = 0;
    bit stray_done = 0;
    int e_cd = 0;
    logic [OPW-1:0] e_a1 = '0, e_a2 = '0;

    initial forever begin
        logic [2*OPW-1:0] prod;
        @(negedge clk);
        eng_done = 1'b0;
        if (e_cd > 0) begin
            e_cd--;
            if (e_cd == 0) begin
                eng_done = 1'b1;
                if (eng_force) begin
                    eng_w = f_w; eng_l = f_l; eng_ovf = f_ovf;
                end else begin
                    prod = {{OPW{1'b0}}, e_a1} * {{OPW{1'b0}}, e_a2};
                    eng_w = prod[RW-1:0];
                    eng_l = 6'($countones(prod[RW-1:0]));
                    eng_ovf = |prod[2*OPW-1:RW];
                end
            end
        end
        if (eng_start) begin
            if (eng_rand) e_cd = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 6));
            else e_cd = eng_delay;
            e_a1 = eng_a1; e_a2 = eng_a2;
        end
        if (stray_done) begin
            eng_done = 1'b1; stray_done = 0;
        end
    end

    // ---------------- random requesters and response acceptor ----------------
    bit [1:0] auto_req = 2'b00;
    bit rsp_rand = 0;

    task automatic agent(input int i);
        forever begin
            @(negedge clk);
            if (auto_req[i]) begin
                if (req_valid[i] && req_ready[i]) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    if (i == 0) begin
                        req0_a1 = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF : 24'($urandom);
                        req0_a2 = 24'($urandom);
                    end else begin
                        req1_a1 = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF : 24'($urandom);
                        req1_a2 = 24'($urandom_range(0, 4095));
                    end
                    req_valid[i] = 1'b1;
                end
            end
        end
    endtask

    initial agent(0);
    initial agent(1);

    initial forever begin
        @(negedge clk);
        if (rsp_rand) rsp_ready = 2'($urandom_range(0, 3));
    end

    // ---------------- directed helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        n_reset = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
        repeat (3) @(negedge clk);
        n_reset = 1'b1;
    endtask

    task automatic do_job(input int i, input logic [OPW-1:0] a1, input logic [OPW-1:0] a2,
                          input int hold, output logic [RW-1:0] w, output logic [5:0] l,
                          output logic [1:0] st, output int wc);
        int k;
        logic [1:0] oh;
        oh = (i == 1) ? 2'b10 : 2'b01;
        @(negedge clk);
        if (i == 0) begin req0_a1 = a1; req0_a2 = a2; end
        else begin req1_a1 = a1; req1_a2 = a2; end
        req_valid[i] = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!req_ready[i] && k < 20);
        chk("grant_seen", req_ready, oh);
        req_valid[i] = 1'b0;
        @(negedge clk);
        chk("start_after_ready", eng_start, 1'b1);
        wc = 0; k = 0;
        while (!rsp_valid[i] && k < 200) begin wc++; @(negedge clk); k++; end
        chk("rsp_arrived", rsp_valid, oh);
        w = rsp_w; l = rsp_l; st = rsp_status;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", rsp_valid, oh);
            chk("hold_w", rsp_w, w);
        end
        rsp_ready[i] = 1'b1;
        @(negedge clk);
        rsp_ready[i] = 1'b0;
        chk("rsp_cleared", rsp_valid, 2'b00);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [RW-1:0] w;
        logic [5:0] l;
        logic [1:0] st;
        int wc, k, ng;
        int order[3];
        logic [15:0] cnt_before;

        do_reset();
        chk_en = 1'b1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_rsp_valid", rsp_valid, 2'b00);
        chk("reset_op_count", op_count, 16'h0000);
        chk("reset_eng_a1", eng_a1, 24'h0);

        // basic job from requester 0
        eng_delay = 3;
        do_job(0, 24'h000003, 24'h000005, 0, w, l, st, wc);
        chk("t1_w", w, 32'd15);
        chk("t1_l", l, 6'd4);
        chk("t1_status", st, 2'b00);
        chk("t1_op_count", op_count, 16'd1);

        // both requesters continuously valid after reset
        do_reset();
        eng_delay = 2;
        req0_a1 = 24'd2; req0_a2 = 24'd3; req1_a1 = 24'd7; req1_a2 = 24'd9;
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        ng = 0; k = 0;
        while (ng < 3 && k < 400) begin
            @(negedge clk); k++;
            if (req_ready != 2'b00) begin
                order[ng] = req_ready[1] ? 1 : 0;
                ng++;
            end
        end
        req_valid = 2'b00;
        chk("t2_grants", ng, 3);
        k = 0;
        while (busy && k < 100) begin @(negedge clk); k++; end
        rsp_ready = 2'b00;
        chk("t2_g0", order[0], 0);
        chk("t2_g1", order[1], 1);
        chk("t2_g2", order[2], 0);
        chk("t2_op_count", op_count, 16'd3);

        // overflow reported by engine
        eng_force = 1; f_w = 32'h00000001; f_l = 6'd1; f_ovf = 1'b1;
        do_job(1, 24'hFFFFFF, 24'hFFFFFF, 0, w, l, st, wc);
        eng_force = 0;
        chk("t3_status", st, 2'b01);
        chk("t3_w", w, 32'h00000001);

        // engine never answers
        eng_delay = 0;
        cnt_before = op_count;
        do_job(0, 24'h000010, 24'h000010, 0, w, l, st, wc);
        chk("t4_wait_cycles", wc, TIMEOUT);
        chk("t4_status", st, 2'b10);
        chk("t4_w", w, 32'h0);
        chk("t4_op_count", op_count, cnt_before + 16'd1);
        stray_done = 1;
        repeat (3) @(negedge clk);
        chk("t4_stray_busy", busy, 1'b0);
        chk("t4_stray_count", op_count, cnt_before + 16'd1);

        // done coincides with last timeout cycle, response held 10 cycles
        eng_delay = TIMEOUT - 1;
        do_job(1, 24'h000100, 24'h000100, 10, w, l, st, wc);
        chk("t5_wait_cycles", wc, TIMEOUT);
        chk("t5_status", st, 2'b00);
        chk("t5_w", w, 32'h00010000);
        chk("t5_l", l, 6'd1);

        // reset during WAIT
        eng_delay = 0;
        @(negedge clk);
        req0_a1 = 24'h000123; req0_a2 = 24'h000456;
        req_valid[0] = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!req_ready[0] && k < 20);
        req_valid[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("t6_in_wait", busy, 1'b1);
        n_reset = 1'b0;
        @(negedge clk);
        chk("t6_busy", busy, 1'b0);
        chk("t6_rsp_valid", rsp_valid, 2'b00);
        chk("t6_op_count", op_count, 16'h0);
        chk("t6_eng_a1", eng_a1, 24'h0);
        chk("t6_eng_start", eng_start, 1'b0);
        chk("t6_status", rsp_status, 2'b00);
        n_reset = 1'b1;

        // op_count wrap
        @(posedge clk); #1;
        dut.op_count_q = 16'hFFFF;
        m_count = 16'hFFFF;
        eng_delay = 2;
        do_job(0, 24'h000002, 24'h000002, 0, w, l, st, wc);
        chk("t7_wrap", op_count, 16'h0000);

        // random traffic
        do_reset();
        eng_rand = 1; rsp_rand = 1; auto_req = 2'b11;
        repeat (4000) @(negedge clk);
        auto_req = 2'b00;
        req_valid = 2'b00;
        k = 0;
        while ((busy || req_ready != 2'b00) && k < 400) begin @(negedge clk); k++; end
        chk("rand_drained", busy, 1'b0);
        rsp_rand = 0; rsp_ready = 2'b00;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
